// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline memory stage.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int XLEN            = 32;

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: loads on completion, otherwise inserts a bubble.
module mem_wb_pipe_reg
  import riscv_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_ld_load,
  input  logic            i_rf_en,
  input  logic            i_err,
  input  logic [1:0]      i_wb_sel,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic [XLEN-1:0] i_ld_data,
  output logic            o_valid,
  output logic            o_rf_en,
  output logic            o_err,
  output logic [1:0]      o_wb_sel,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_alu_res,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_ld_data
);

  logic            r_valid;
  logic            r_rf_en;
  logic            r_err;
  logic [1:0]      r_wb_sel;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu_res;
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] r_ld_data;

  // Payload fields hold during bubbles; only valid and err drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_rf_en   <= 1'b0;
      r_err     <= 1'b0;
      r_wb_sel  <= '0;
      r_rd      <= '0;
      r_alu_res <= '0;
      r_next_pc <= '0;
      r_ld_data <= '0;
    end else begin
      r_valid <= i_load;
      r_err   <= i_load & i_err;
      if (i_load) begin
        r_rf_en   <= i_rf_en;
        r_wb_sel  <= i_wb_sel;
        r_rd      <= i_rd;
        r_alu_res <= i_alu_res;
        r_next_pc <= i_next_pc;
      end
      if (i_ld_load) begin
        r_ld_data <= i_ld_data;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_rf_en   = r_rf_en & r_valid;
  assign o_err     = r_err;
  assign o_wb_sel  = r_wb_sel;
  assign o_rd      = r_rd;
  assign o_alu_res = r_alu_res;
  assign o_next_pc = r_next_pc;
  assign o_ld_data = r_ld_data;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory handshake, front-end stall, MEM/WB register.
// Optional MEM_STAGE_ALIGN_CHECK_EN rejects misaligned word accesses without a request.
module mem_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_mem_i,
  input  logic        rf_en_mem_i,
  input  logic [1:0]  wb_sel_mem_i,
  input  logic        mem_wr_mem_i,
  input  logic        is_lw_mem_i,
  input  logic [4:0]  rd_mem_i,
  input  logic [31:0] alu_res_mem_i,
  input  logic [31:0] next_seq_pc_mem_i,
  input  logic [31:0] r_data_p2_mem_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_mem_o,
  output logic        valid_wb_o,
  output logic        rf_en_wb_o,
  output logic [1:0]  wb_sel_wb_o,
  output logic [4:0]  rd_wb_o,
  output logic [31:0] alu_res_wb_o,
  output logic [31:0] next_seq_pc_wb_o,
  output logic [31:0] ld_data_wb_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic w_mem_op;
  logic w_misalign;
  logic w_timeout;
  logic w_req;
  logic w_complete;
  logic w_abort;
  logic w_ld_cap;

  assign w_mem_op  = valid_mem_i & (is_lw_mem_i | mem_wr_mem_i);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign w_misalign = |alu_res_mem_i[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A timed-out wait takes priority over a late grant or response.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_ld_cap    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_misalign) begin
            w_complete = 1'b1;
            w_abort    = 1'b1;
          end else begin
            w_req = 1'b1;
            if (!dmem_gnt_i) begin
              w_state_nxt = REQ;
            end else if (mem_wr_mem_i) begin
              w_complete = 1'b1;
            end else begin
              w_state_nxt = RESP;
            end
          end
        end else if (valid_mem_i) begin
          w_complete = 1'b1;
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (w_timeout) begin
          w_complete  = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (dmem_gnt_i) begin
          if (mem_wr_mem_i) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (w_timeout) begin
          w_complete  = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (dmem_rvalid_i) begin
          w_complete  = 1'b1;
          w_ld_cap    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dmem_req_o   = w_req & ~reset;
  assign dmem_we_o    = mem_wr_mem_i;
  assign dmem_addr_o  = alu_res_mem_i;
  assign dmem_wdata_o = r_data_p2_mem_i;
  assign stall_mem_o  = w_mem_op & ~w_complete & ~reset;

  mem_wb_pipe_reg u_mem_wb (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_complete),
    .i_ld_load (w_ld_cap),
    .i_rf_en   (rf_en_mem_i & ~w_abort),
    .i_err     (w_abort),
    .i_wb_sel  (wb_sel_mem_i),
    .i_rd      (rd_mem_i),
    .i_alu_res (alu_res_mem_i),
    .i_next_pc (next_seq_pc_mem_i),
    .i_ld_data (dmem_rdata_i),
    .o_valid   (valid_wb_o),
    .o_rf_en   (rf_en_wb_o),
    .o_err     (err_o),
    .o_wb_sel  (wb_sel_wb_o),
    .o_rd      (rd_wb_o),
    .o_alu_res (alu_res_wb_o),
    .o_next_pc (next_seq_pc_wb_o),
    .o_ld_data (ld_data_wb_o)
  );

endmodule
